tl_fc_dllp_rx: RTL and testbench
================================

Name: tl_fc_dllp_rx

Overview:
- Receive-side flow-control DLLP decoder for VC0.
- Consumes CRC-checked DLLP bodies from the data-link layer and runs the FC_INIT1/FC_INIT2/active sequence.
- Tracks the last advertised credit limit per credit type and converts cumulative limits into one-cycle credit increments.
- Output directly drives the fc_update_i/fc_valid_i inputs of tl_credit_mgr.

Parameters:
- HDR_W, 8, header credit field width (PH/NPH/CPLH)
- DATA_W, 12, data credit field width (PD/NPD/CPLD)
- VC_ID, 0, virtual channel accepted; DLLPs for other VCs are ignored

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- link_up_i  in  1  DL_Up; low forces re-initialisation
- dllp_valid_i  in  1  one DLLP body this cycle, CRC already good
- dllp_data_i  in  32  [31:24] type, [21:14] HdrFC, [11:0] DataFC
- fc_update_o  out  tl_pkg::tl_credit_t  credit increments; 8-bit hdr fields, 12-bit data fields
- fc_valid_o  out  1  fc_update_o valid, single-cycle pulse
- fc_init_done_o  out  1  FC init complete (state ACTIVE)
- fc_err_o  out  1  pulse: protocol violation on an UpdateFC

Behaviour:
- Reset values: all outputs 0, all limits 0, infinite flags clear, state INIT1.
- Type decode uses [31:24] with [26:24] = VC.
  - InitFC1: 0x40 P, 0x50 NP, 0x60 Cpl.
  - InitFC2: 0xC0/0xD0/0xE0.
  - UpdateFC: 0x80/0x90/0xA0.
  - Any other type, or a VC other than VC_ID, is ignored with no output.
- At most one DLLP per cycle. No backpressure.
- Latency: output appears exactly 1 cycle after the accepted DLLP, registered.
- Each fc_valid_o pulse carries only the hdr+data fields of the DLLP's type. All other fields are 0.
- FSM:
  - INIT1:
    - The first InitFC1 per type is latched into that type's limits. Then emit increment = advertised value, or all-ones if the field is 0; a 0 field sets the infinite flag for that field.
    - Repeated InitFC1 for an already-seen type is ignored.
    - InitFC2 and UpdateFC are ignored.
    - When all three types have been seen (the seen-mask becomes 3'b111, including the same-cycle update), the next state is INIT2.
  - INIT2:
    - InitFC1 and InitFC2 produce no output.
    - The first InitFC2 or UpdateFC moves the FSM to ACTIVE.
    - An UpdateFC that triggers this transition is also processed as in ACTIVE, in the same cycle.
  - ACTIVE:
    - fc_init_done_o = 1.
    - On UpdateFC, per field: delta = (new - last) mod 2^W, where W is that field's width.
    - If the delta for the hdr or the data field is > 2^(W-1), pulse fc_err_o, drop the whole DLLP (no limit change, no fc_valid_o).
    - Otherwise set last <= new and emit the deltas.
    - A field with its infinite flag set always emits 0 and never updates.
    - If both deltas are 0, no fc_valid_o pulse.
    - InitFC1/InitFC2 are ignored.
- Wrap-around: the modulo subtraction handles limit rollover. Example: hdr last 8'hF0, new 8'h10 gives delta 8'h20.
- link_up_i low:
  - Synchronous return to INIT1.
  - Clears the seen-mask, limits, infinite flags and fc_init_done_o.
  - Suppresses any output in that cycle; a DLLP present in that cycle is dropped.
- rst has priority over link_up_i.
- Reset mid-sequence discards all state. No pulse is emitted on the cycle after reset.

Test Plan:
- Init: InitFC1-P hdr 8'd32 data 12'd256 -> next cycle fc_valid_o=1, ph=32, pd=256, others 0. Then NP (16,0) -> nph=16, npd=12'hFFF, npd infinite. Then Cpl (0,0) -> cplh=8'hFF, cpld=12'hFFF. State INIT2, fc_init_done_o=0.
- Completion: in INIT2, InitFC2-P -> no fc_valid_o, fc_init_done_o=1 next cycle. Then UpdateFC-P hdr 40 data 300 -> ph=8, pd=44.
- Wrap: P limits hdr 8'hF8/data 12'hFF0, UpdateFC hdr 8'h08 data 12'h010 -> ph=8'h10, pd=12'h020.
- Error: P hdr limit 8'h10, UpdateFC hdr 8'h95 (delta 0x85 > 0x80) -> fc_err_o=1 one cycle, fc_valid_o=0. A following UpdateFC hdr 8'h12 -> ph=2.
- Infinite/no-change/filter: UpdateFC-NP data 500 after NPD infinite, hdr unchanged -> no pulse. UpdateFC-P with VC=1 -> no pulse. Unknown type 0x00 -> no pulse.
- link_up_i dropped for 1 cycle in ACTIVE with a concurrent UpdateFC -> no pulse, fc_init_done_o=0. Re-init InitFC1-P (32,256) -> ph=32, pd=256 emitted again.

Source files
------------

// File: rtl/tl_fc_dllp_rx.sv
// Receive-side flow-control DLLP decoder for VC0: runs FC_INIT1/FC_INIT2/active
// and turns cumulative advertised credit limits into one-cycle increments.
package tl_pkg;
  typedef struct packed {
    logic [7:0]  ph;
    logic [11:0] pd;
    logic [7:0]  nph;
    logic [11:0] npd;
    logic [7:0]  cplh;
    logic [11:0] cpld;
  } tl_credit_t;
endpackage

module tl_fc_dllp_rx #(
  parameter int unsigned HDR_W  = 8,
  parameter int unsigned DATA_W = 12,
  parameter int unsigned VC_ID  = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               link_up_i,
  input  logic               dllp_valid_i,
  input  logic [31:0]        dllp_data_i,
  output tl_pkg::tl_credit_t fc_update_o,
  output logic               fc_valid_o,
  output logic               fc_init_done_o,
  output logic               fc_err_o
);

  localparam logic [2:0]        VcId     = 3'(VC_ID);
  localparam logic [HDR_W-1:0]  HdrHalf  = {1'b1, {(HDR_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] DataHalf = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {StInit1, StInit2, StActive} state_e;

  state_e             state_q, state_d;
  logic [2:0]         seen_q, seen_d;
  logic [2:0]         hdr_inf_q, hdr_inf_d;
  logic [2:0]         data_inf_q, data_inf_d;
  logic [HDR_W-1:0]   hdr_lim_q [3];
  logic [HDR_W-1:0]   hdr_lim_d [3];
  logic [DATA_W-1:0]  data_lim_q [3];
  logic [DATA_W-1:0]  data_lim_d [3];
  tl_pkg::tl_credit_t upd_q, upd_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;

  logic [7:0]        dtype;
  logic              vc_ok, is_init1, is_init2, is_upd;
  logic [1:0]        idx;
  logic [HDR_W-1:0]  hdr_fc, hdr_delta;
  logic [DATA_W-1:0] data_fc, data_delta;
  logic              do_update;
  logic              unused_bits;

  assign unused_bits = ^{dllp_data_i[23:22], dllp_data_i[13:12]};

  // Place a header/data increment pair into the slot of the given credit type.
  function automatic tl_pkg::tl_credit_t pack(input logic [1:0] sel,
                                              input logic [HDR_W-1:0] h,
                                              input logic [DATA_W-1:0] d);
    tl_pkg::tl_credit_t c;
    c = '0;
    case (sel)
      2'd0:    begin c.ph   = h; c.pd   = d; end
      2'd1:    begin c.nph  = h; c.npd  = d; end
      default: begin c.cplh = h; c.cpld = d; end
    endcase
    return c;
  endfunction

  always_comb begin
    dtype    = dllp_data_i[31:24];
    hdr_fc   = dllp_data_i[14 +: HDR_W];
    data_fc  = dllp_data_i[0 +: DATA_W];
    vc_ok    = dllp_valid_i && !dtype[3] && (dtype[2:0] == VcId);
    is_init1 = 1'b0;
    is_init2 = 1'b0;
    is_upd   = 1'b0;
    idx      = 2'd0;
    case (dtype[7:4])
      4'h4: begin is_init1 = vc_ok; idx = 2'd0; end
      4'h5: begin is_init1 = vc_ok; idx = 2'd1; end
      4'h6: begin is_init1 = vc_ok; idx = 2'd2; end
      4'hC: begin is_init2 = vc_ok; idx = 2'd0; end
      4'hD: begin is_init2 = vc_ok; idx = 2'd1; end
      4'hE: begin is_init2 = vc_ok; idx = 2'd2; end
      4'h8: begin is_upd   = vc_ok; idx = 2'd0; end
      4'h9: begin is_upd   = vc_ok; idx = 2'd1; end
      4'hA: begin is_upd   = vc_ok; idx = 2'd2; end
      default: ;
    endcase
    // Infinite fields contribute a zero delta and can never raise an error.
    hdr_delta  = hdr_inf_q[idx]  ? '0 : hdr_fc  - hdr_lim_q[idx];
    data_delta = data_inf_q[idx] ? '0 : data_fc - data_lim_q[idx];
  end

  always_comb begin
    state_d    = state_q;
    seen_d     = seen_q;
    hdr_inf_d  = hdr_inf_q;
    data_inf_d = data_inf_q;
    hdr_lim_d  = hdr_lim_q;
    data_lim_d = data_lim_q;
    upd_d      = '0;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    do_update  = 1'b0;

    if (!link_up_i) begin
      state_d    = StInit1;
      seen_d     = '0;
      hdr_inf_d  = '0;
      data_inf_d = '0;
      hdr_lim_d  = '{default: '0};
      data_lim_d = '{default: '0};
    end else begin
      case (state_q)
        StInit1: begin
          if (is_init1 && !seen_q[idx]) begin
            seen_d[idx]     = 1'b1;
            hdr_lim_d[idx]  = hdr_fc;
            data_lim_d[idx] = data_fc;
            hdr_inf_d[idx]  = (hdr_fc == '0);
            data_inf_d[idx] = (data_fc == '0);
            valid_d         = 1'b1;
            upd_d           = pack(idx, (hdr_fc == '0) ? '1 : hdr_fc,
                                   (data_fc == '0) ? '1 : data_fc);
          end
          if (seen_d == 3'b111) state_d = StInit2;
        end
        StInit2: begin
          if (is_init2 || is_upd) state_d = StActive;
          do_update = is_upd;
        end
        StActive: do_update = is_upd;
        default:  state_d = StInit1;
      endcase

      if (do_update) begin
        if (hdr_delta > HdrHalf || data_delta > DataHalf) begin
          err_d = 1'b1;
        end else begin
          if (!hdr_inf_q[idx])  hdr_lim_d[idx]  = hdr_fc;
          if (!data_inf_q[idx]) data_lim_d[idx] = data_fc;
          if (hdr_delta != '0 || data_delta != '0) begin
            valid_d = 1'b1;
            upd_d   = pack(idx, hdr_delta, data_delta);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StInit1;
      seen_q     <= '0;
      hdr_inf_q  <= '0;
      data_inf_q <= '0;
      hdr_lim_q  <= '{default: '0};
      data_lim_q <= '{default: '0};
      upd_q      <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      seen_q     <= seen_d;
      hdr_inf_q  <= hdr_inf_d;
      data_inf_q <= data_inf_d;
      hdr_lim_q  <= hdr_lim_d;
      data_lim_q <= data_lim_d;
      upd_q      <= upd_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign fc_update_o    = upd_q;
  assign fc_valid_o     = valid_q;
  assign fc_err_o       = err_q;
  assign fc_init_done_o = (state_q == StActive);

endmodule

// File: tb/tb_tl_fc_dllp_rx.sv
// Directed bench for tl_fc_dllp_rx: init sequence, updates, wrap, errors, filtering, link drop.
module tb_tl_fc_dllp_rx;

  logic               clk;
  logic               rst;
  logic               link_up_i;
  logic               dllp_valid_i;
  logic [31:0]        dllp_data_i;
  tl_pkg::tl_credit_t fc_update_o;
  logic               fc_valid_o;
  logic               fc_init_done_o;
  logic               fc_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  tl_fc_dllp_rx dut (
    .clk            (clk),
    .rst            (rst),
    .link_up_i      (link_up_i),
    .dllp_valid_i   (dllp_valid_i),
    .dllp_data_i    (dllp_data_i),
    .fc_update_o    (fc_update_o),
    .fc_valid_o     (fc_valid_o),
    .fc_init_done_o (fc_init_done_o),
    .fc_err_o       (fc_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [7:0] t, input logic [7:0] h,
                                     input logic [11:0] d);
    return {t, 2'b00, h, 2'b00, d};
  endfunction

  function automatic tl_pkg::tl_credit_t cr(input logic [7:0] ph, input logic [11:0] pd,
                                            input logic [7:0] nph, input logic [11:0] npd,
                                            input logic [7:0] cplh, input logic [11:0] cpld);
    tl_pkg::tl_credit_t c;
    c.ph = ph; c.pd = pd; c.nph = nph; c.npd = npd; c.cplh = cplh; c.cpld = cpld;
    return c;
  endfunction

  // Present one DLLP for one cycle; returns #1 after the capturing edge.
  task automatic send(input logic [31:0] d);
    dllp_valid_i = 1'b1;
    dllp_data_i  = d;
    @(posedge clk);
    #1;
    dllp_valid_i = 1'b0;
    dllp_data_i  = '0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pulse(input string tag, input tl_pkg::tl_credit_t e);
    check_eq({tag, "_valid"}, 64'(fc_valid_o), 64'd1);
    check_eq({tag, "_upd"}, 64'(fc_update_o), 64'(e));
    check_eq({tag, "_err"}, 64'(fc_err_o), 64'd0);
  endtask

  task automatic expect_none(input string tag);
    check_eq({tag, "_valid"}, 64'(fc_valid_o), 64'd0);
  endtask

  initial begin
    rst          = 1'b1;
    link_up_i    = 1'b1;
    dllp_valid_i = 1'b0;
    dllp_data_i  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", 64'(fc_valid_o), 64'd0);
    check_eq("rst_upd",   64'(fc_update_o), 64'd0);
    check_eq("rst_done",  64'(fc_init_done_o), 64'd0);
    check_eq("rst_err",   64'(fc_err_o), 64'd0);
    rst = 1'b0;
    idle();
    expect_none("post_rst");

    // Init sequence
    send(mk(8'h40, 8'd32, 12'd256));
    expect_pulse("init_p", cr(8'd32, 12'd256, 0, 0, 0, 0));
    check_eq("init_p_done", 64'(fc_init_done_o), 64'd0);
    send(mk(8'h40, 8'd50, 12'd50));
    expect_none("init_p_repeat");
    send(mk(8'h80, 8'd50, 12'd50));
    expect_none("init1_upd_ignored");
    send(mk(8'h50, 8'd16, 12'd0));
    expect_pulse("init_np", cr(0, 0, 8'd16, 12'hFFF, 0, 0));
    send(mk(8'h60, 8'd0, 12'd0));
    expect_pulse("init_cpl", cr(0, 0, 0, 0, 8'hFF, 12'hFFF));
    idle();
    check_eq("init2_done", 64'(fc_init_done_o), 64'd0);
    send(mk(8'h40, 8'd32, 12'd256));
    expect_none("init2_fc1");

    // Completion
    send(mk(8'hC0, 8'd32, 12'd256));
    expect_none("fc2");
    check_eq("active_done", 64'(fc_init_done_o), 64'd1);
    send(mk(8'h80, 8'd40, 12'd300));
    expect_pulse("upd1", cr(8'd8, 12'd44, 0, 0, 0, 0));

    // Walk limits up to F8/FF0 then wrap
    send(mk(8'h80, 8'h90, 12'h900));
    expect_pulse("walk1", cr(8'h68, 12'h7D4, 0, 0, 0, 0));
    send(mk(8'h80, 8'hF8, 12'hFF0));
    expect_pulse("walk2", cr(8'h68, 12'h6F0, 0, 0, 0, 0));
    send(mk(8'h80, 8'h08, 12'h010));
    expect_pulse("wrap", cr(8'h10, 12'h020, 0, 0, 0, 0));

    // Error
    send(mk(8'h80, 8'h10, 12'h010));
    expect_pulse("to10", cr(8'h08, 12'h000, 0, 0, 0, 0));
    send(mk(8'h80, 8'h95, 12'h010));
    check_eq("err_pulse", 64'(fc_err_o), 64'd1);
    expect_none("err");
    idle();
    check_eq("err_single", 64'(fc_err_o), 64'd0);
    send(mk(8'h80, 8'h12, 12'h010));
    expect_pulse("after_err", cr(8'h02, 12'h000, 0, 0, 0, 0));
    send(mk(8'h80, 8'h92, 12'h010));
    expect_pulse("half_edge", cr(8'h80, 12'h000, 0, 0, 0, 0));

    // Infinite / no change / filtering
    send(mk(8'h90, 8'd16, 12'd500));
    expect_none("np_inf_nochg");
    send(mk(8'h90, 8'd20, 12'd700));
    expect_pulse("np_hdr_only", cr(0, 0, 8'd4, 12'd0, 0, 0));
    send(mk(8'h81, 8'hA0, 12'h010));
    expect_none("vc1");
    send(mk(8'h00, 8'hA0, 12'h010));
    expect_none("type00");
    send(mk(8'hA0, 8'h33, 12'h123));
    expect_none("cpl_inf");

    // Link drop with concurrent UpdateFC
    link_up_i = 1'b0;
    send(mk(8'h80, 8'hA0, 12'h010));
    link_up_i = 1'b1;
    expect_none("linkdown");
    check_eq("linkdown_done", 64'(fc_init_done_o), 64'd0);
    send(mk(8'h40, 8'd32, 12'd256));
    expect_pulse("reinit_p", cr(8'd32, 12'd256, 0, 0, 0, 0));

    // Reset mid-sequence with a DLLP present
    rst = 1'b1;
    send(mk(8'h50, 8'd16, 12'd0));
    rst = 1'b0;
    expect_none("rst_mid");
    idle();
    expect_none("rst_mid_next");
    send(mk(8'h40, 8'd7, 12'd9));
    expect_pulse("rst_reinit", cr(8'd7, 12'd9, 0, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
